// File: rtl/pc_gen_if.sv
// Request/response bundle between the fetch-control logic and the pc generator.
interface pc_gen_if #(parameter int XLEN = 32);
  logic            stall;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic            mret_valid;
  logic [XLEN-1:0] mepc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            call_valid;
  logic [XLEN-1:0] call_target;
  logic            ret_valid;
  logic [XLEN-1:0] ret_target;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_prev;
  logic            misaligned;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    output stall, trap_valid, trap_vector, mret_valid, mepc,
           redirect_valid, redirect_target, call_valid, call_target,
           ret_valid, ret_target,
    input  pc, pc_plus4, pc_prev, misaligned, ras_empty, ras_full
  );

  modport slave (
    input  stall, trap_valid, trap_vector, mret_valid, mepc,
           redirect_valid, redirect_target, call_valid, call_target,
           ret_valid, ret_target,
    output pc, pc_plus4, pc_prev, misaligned, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch pc generator: priority next-pc mux with a circular return-address stack.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);
  localparam int SW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d, pc_prev_q, pc_prev_d, pc_plus4, tgt;
  logic            mis_q, mis_d, take;
  logic [SW-1:0]   sp_q, sp_d, sp_m1, wr_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  assign pc_plus4 = pc_q + XLEN'(4);
  assign sp_m1    = sp_q - SW'(1);

  always_comb begin
    pc_d   = pc_q;
    mis_d  = mis_q;
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    push   = 1'b0;
    wr_idx = sp_q;
    take   = 1'b0;
    tgt    = '0;
    if (bus.trap_valid) begin
      take = 1'b1; tgt = bus.trap_vector;
    end else if (bus.mret_valid) begin
      take = 1'b1; tgt = bus.mepc;
    end else if (bus.redirect_valid) begin
      take = 1'b1; tgt = bus.redirect_target;
    end else if (!bus.stall && bus.call_valid) begin
      take = 1'b1;
      tgt  = bus.call_target;
      push = 1'b1;
      // call+ret on a non-empty stack rewrites the top in place
      if (bus.ret_valid && cnt_q != '0) begin
        wr_idx = sp_m1;
      end else begin
        sp_d  = sp_q + SW'(1);
        cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + CW'(1);
      end
    end else if (!bus.stall && bus.ret_valid) begin
      take = 1'b1;
      if (cnt_q != '0) begin
        tgt   = ras_q[sp_m1];
        sp_d  = sp_m1;
        cnt_d = cnt_q - CW'(1);
      end else begin
        tgt = bus.ret_target;
      end
    end else if (!bus.stall) begin
      pc_d  = pc_plus4;
      mis_d = 1'b0;
    end
    if (take) begin
      pc_d  = {tgt[XLEN-1:2], 2'b00};
      mis_d = |tgt[1:0];
    end
    pc_prev_d = (pc_d != pc_q) ? pc_q : pc_prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_VEC;
      pc_prev_q <= RESET_VEC;
      mis_q     <= 1'b0;
      sp_q      <= '0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      pc_prev_q <= pc_prev_d;
      mis_q     <= mis_d;
      sp_q      <= sp_d;
      cnt_q     <= cnt_d;
    end
  end

  // Stack storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) ras_q[wr_idx] <= pc_plus4;
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.pc_prev    = pc_prev_q;
  assign bus.misaligned = mis_q;
  assign bus.ras_empty  = (cnt_q == '0);
  assign bus.ras_full   = (cnt_q == FULL);
endmodule

// File: tb/tb_pc_gen.sv
// Directed vector table plus hand sequences for reset, wrap and mid-call reset.
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32)) bus();
  pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic        stall;
    logic        trap;  logic [31:0] tv;
    logic        mret;  logic [31:0] mepc;
    logic        rd;    logic [31:0] rt;
    logic        call;  logic [31:0] ct;
    logic        ret;   logic [31:0] rtt;
    logic [31:0] epc;   logic [31:0] eprev;
    logic        emis;  logic        eempty; logic efull;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.stall = 0; bus.trap_valid = 0; bus.trap_vector = 0; bus.mret_valid = 0; bus.mepc = 0;
    bus.redirect_valid = 0; bus.redirect_target = 0; bus.call_valid = 0; bus.call_target = 0;
    bus.ret_valid = 0; bus.ret_target = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] epc, input logic [31:0] eprev,
                           input logic emis, input logic eempty, input logic efull);
    chk({tag, ".pc"}, bus.pc, epc);
    chk({tag, ".pc_plus4"}, bus.pc_plus4, epc + 32'd4);
    chk({tag, ".pc_prev"}, bus.pc_prev, eprev);
    chk({tag, ".misaligned"}, {31'd0, bus.misaligned}, {31'd0, emis});
    chk({tag, ".ras_empty"}, {31'd0, bus.ras_empty}, {31'd0, eempty});
    chk({tag, ".ras_full"}, {31'd0, bus.ras_full}, {31'd0, efull});
  endtask

  vec_t tbl [29];

  initial begin
    //        stall trap tv       mret mepc      rd rt            call ct        ret rtt        epc        eprev      mis emp full
    tbl[0]  = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h004,  32'h000,   0, 1, 0};
    tbl[1]  = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h008,  32'h004,   0, 1, 0};
    tbl[2]  = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h00C,  32'h008,   0, 1, 0};
    tbl[3]  = '{1, 0, 32'h0,  0, 32'h0,    1, 32'h103,      0, 32'h0,   0, 32'h0,   32'h100,  32'h00C,   1, 1, 0};
    tbl[4]  = '{1, 0, 32'h0,  0, 32'h0,    0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h100,  32'h00C,   1, 1, 0};
    tbl[5]  = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h104,  32'h100,   0, 1, 0};
    tbl[6]  = '{0, 0, 32'h0,  0, 32'h0,    1, 32'h10,       0, 32'h0,   0, 32'h0,   32'h010,  32'h104,   0, 1, 0};
    tbl[7]  = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        1, 32'h20,  0, 32'h0,   32'h020,  32'h010,   0, 0, 0};
    tbl[8]  = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        1, 32'h30,  0, 32'h0,   32'h030,  32'h020,   0, 0, 0};
    tbl[9]  = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        1, 32'h40,  0, 32'h0,   32'h040,  32'h030,   0, 0, 0};
    tbl[10] = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        1, 32'h50,  0, 32'h0,   32'h050,  32'h040,   0, 0, 1};
    tbl[11] = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        1, 32'h60,  0, 32'h0,   32'h060,  32'h050,   0, 0, 1};
    tbl[12] = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        0, 32'h0,   1, 32'hF00, 32'h054,  32'h060,   0, 0, 0};
    tbl[13] = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        0, 32'h0,   1, 32'hF00, 32'h044,  32'h054,   0, 0, 0};
    tbl[14] = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        0, 32'h0,   1, 32'hF00, 32'h034,  32'h044,   0, 0, 0};
    tbl[15] = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        0, 32'h0,   1, 32'hF00, 32'h024,  32'h034,   0, 1, 0};
    tbl[16] = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        0, 32'h0,   1, 32'hF00, 32'hF00,  32'h024,   0, 1, 0};
    tbl[17] = '{0, 1, 32'h80, 1, 32'h90,   1, 32'hA0,       1, 32'h300, 0, 32'h0,   32'h080,  32'hF00,   0, 1, 0};
    tbl[18] = '{0, 0, 32'h0,  0, 32'h0,    1, 32'h4FC,      0, 32'h0,   0, 32'h0,   32'h4FC,  32'h080,   0, 1, 0};
    tbl[19] = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        1, 32'h200, 0, 32'h0,   32'h200,  32'h4FC,   0, 0, 0};
    tbl[20] = '{0, 0, 32'h0,  0, 32'h0,    1, 32'h200,      1, 32'h300, 1, 32'h0,   32'h200,  32'h4FC,   0, 0, 0};
    tbl[21] = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        1, 32'h300, 1, 32'h0,   32'h300,  32'h200,   0, 0, 0};
    tbl[22] = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        0, 32'h0,   1, 32'hF00, 32'h204,  32'h300,   0, 1, 0};
    tbl[23] = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        1, 32'h303, 1, 32'h0,   32'h300,  32'h204,   1, 0, 0};
    tbl[24] = '{1, 0, 32'h0,  0, 32'h0,    0, 32'h0,        1, 32'h400, 0, 32'h0,   32'h300,  32'h204,   1, 0, 0};
    tbl[25] = '{1, 0, 32'h0,  0, 32'h0,    0, 32'h0,        0, 32'h0,   1, 32'h0,   32'h300,  32'h204,   1, 0, 0};
    tbl[26] = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        0, 32'h0,   1, 32'hF00, 32'h208,  32'h300,   0, 1, 0};
    tbl[27] = '{1, 0, 32'h0,  1, 32'h1002, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h1000, 32'h208,   1, 1, 0};
    tbl[28] = '{0, 0, 32'h0,  0, 32'h0,    0, 32'h0,        0, 32'h0,   1, 32'h777, 32'h774,  32'h1000,  1, 1, 0};

    idle();
    rst = 1'b1;
    step(); step();
    chk_state("reset", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      bus.stall = tbl[i].stall;
      bus.trap_valid = tbl[i].trap; bus.trap_vector = tbl[i].tv;
      bus.mret_valid = tbl[i].mret; bus.mepc = tbl[i].mepc;
      bus.redirect_valid = tbl[i].rd; bus.redirect_target = tbl[i].rt;
      bus.call_valid = tbl[i].call; bus.call_target = tbl[i].ct;
      bus.ret_valid = tbl[i].ret; bus.ret_target = tbl[i].rtt;
      step();
      chk_state($sformatf("vec%0d", i), tbl[i].epc, tbl[i].eprev, tbl[i].emis,
                tbl[i].eempty, tbl[i].efull);
    end

    // reset during a stalled call clears the stack completely
    idle();
    bus.call_valid = 1; bus.call_target = 32'h10;
    step();
    chk_state("precall", 32'h10, 32'h774, 1'b0, 1'b0, 1'b0);
    bus.call_target = 32'h20; bus.stall = 1; bus.trap_valid = 1; bus.trap_vector = 32'h80;
    rst = 1'b1;
    step();
    chk_state("midrst", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    idle();
    bus.ret_valid = 1; bus.ret_target = 32'h44;
    step();
    chk_state("postrst_ret", 32'h44, 32'h0, 1'b0, 1'b1, 1'b0);

    // sequential wrap at the top of the address space
    idle();
    bus.redirect_valid = 1; bus.redirect_target = 32'hFFFF_FFFC;
    step();
    chk("wrap.pc_plus4", bus.pc_plus4, 32'h0);
    idle();
    step();
    chk_state("wrap", 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
